// File: rtl/edge_point_extract.sv
// -----------------------------------------------------------------------------
// edge_point_extract
//
// Turns a raster stream of edge-magnitude pixels into a queue of (x,y) edge
// points for a downstream Hough voter. Each pixel gets a coordinate from the
// frame/line strobes. A pixel becomes a candidate when its magnitude reaches
// Threshold and it lies inside the 1-pixel border that a 3x3 kernel cannot
// cover. Candidates pass through one register stage and are then pushed into a
// first-word-fall-through FIFO. The block also counts the points accepted per
// frame and flags points dropped because the FIFO was full.
//
// Ports
//   Clk, nReset            clock, asynchronous active-low reset
//   PixelIn[7:0]           edge magnitude, one pixel per cycle
//   FrameIn, LineIn        first-pixel-of-frame / first-pixel-of-line strobes
//   Width, Height [7:0]    image size (static within a frame)
//   Threshold[7:0]         minimum magnitude for an edge point
//   PointX, PointY [7:0]   FIFO head coordinate
//   PointValid             FIFO head valid
//   PointReady             consumer accepts the head
//   Overflow               sticky: a point was dropped in the current frame
//   EdgeCount[15:0]        accepted points of the previous frame
//   FrameDone              one-cycle pulse when EdgeCount updates
// -----------------------------------------------------------------------------
module edge_point_extract #(
    parameter int DEPTH = 16
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic [7:0]  PixelIn,
    input  logic        FrameIn,
    input  logic        LineIn,
    input  logic [7:0]  Width,
    input  logic [7:0]  Height,
    input  logic [7:0]  Threshold,
    output logic [7:0]  PointX,
    output logic [7:0]  PointY,
    output logic        PointValid,
    input  logic        PointReady,
    output logic        Overflow,
    output logic [15:0] EdgeCount,
    output logic        FrameDone
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic          active_r;
    logic [7:0]    prev_x_r, prev_y_r;
    logic [7:0]    cur_x_s, cur_y_s;
    logic [8:0]    x_max_s, y_max_s;
    logic          cand_s;
    logic          cand_valid_r;
    logic [7:0]    cand_x_r, cand_y_r;

    logic [7:0]    mem_x_r [DEPTH];
    logic [7:0]    mem_y_r [DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r, count_next_s;
    logic          valid_r;
    logic          pop_s, push_s, drop_s, full_s;

    logic [15:0]   frame_cnt_r, frame_cnt_next_s;
    logic [15:0]   edge_count_r;
    logic          done_r;
    logic          ovf_r;

    // Coordinate of the pixel currently on PixelIn; FrameIn also acts as a line start.
    always_comb begin
        cur_x_s = prev_x_r;
        cur_y_s = prev_y_r;
        if (FrameIn) begin
            cur_x_s = 8'd0;
            cur_y_s = 8'd0;
        end else if (LineIn) begin
            cur_x_s = 8'd0;
            cur_y_s = sat_inc8(prev_y_r);
        end else begin
            cur_x_s = sat_inc8(prev_x_r);
            cur_y_s = prev_y_r;
        end
    end

    // Candidate decision: threshold plus border mask; sizes below 3 yield no interior.
    always_comb begin
        x_max_s = {1'b0, Width}  - 9'd2;
        y_max_s = {1'b0, Height} - 9'd2;
        cand_s  = 1'b0;
        if ((active_r || FrameIn) && (PixelIn >= Threshold) &&
            (Width >= 8'd3) && (Height >= 8'd3) &&
            (cur_x_s != 8'd0) && (cur_y_s != 8'd0) &&
            ({1'b0, cur_x_s} <= x_max_s) && ({1'b0, cur_y_s} <= y_max_s)) begin
            cand_s = 1'b1;
        end else begin
            cand_s = 1'b0;
        end
    end

    // FIFO control: a push into a full FIFO survives only if a pop frees a slot that cycle.
    always_comb begin
        pop_s  = valid_r & PointReady;
        full_s = (count_r == FULL_CNT);
        push_s = 1'b0;
        drop_s = 1'b0;
        if (cand_valid_r) begin
            if (!full_s || pop_s) begin
                push_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end
        count_next_s     = count_r + CW'(push_s) - CW'(pop_s);
        frame_cnt_next_s = push_s ? sat_inc16(frame_cnt_r) : frame_cnt_r;
    end

    // Coordinate tracking and the frame-active flag.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            active_r <= 1'b0;
            prev_x_r <= 8'd0;
            prev_y_r <= 8'd0;
        end else begin
            if (FrameIn) begin
                active_r <= 1'b1;
            end
            prev_x_r <= cur_x_s;
            prev_y_r <= cur_y_s;
        end
    end

    // Candidate pipeline stage.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            cand_valid_r <= 1'b0;
            cand_x_r     <= 8'd0;
            cand_y_r     <= 8'd0;
        end else begin
            cand_valid_r <= cand_s;
            cand_x_r     <= cur_x_s;
            cand_y_r     <= cur_y_s;
        end
    end

    // FIFO storage; cleared on reset so the head reads zero while empty after reset.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_x_r[i] <= 8'd0;
                mem_y_r[i] <= 8'd0;
            end
        end else if (push_s) begin
            mem_x_r[wr_ptr_r] <= cand_x_r;
            mem_y_r[wr_ptr_r] <= cand_y_r;
        end
    end

    // FIFO pointers, occupancy and registered head-valid flag.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
            valid_r <= (count_next_s != {CW{1'b0}});
        end
    end

    // Per-frame statistics; a push in the FrameIn cycle still belongs to the old frame.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            frame_cnt_r  <= 16'd0;
            edge_count_r <= 16'd0;
            done_r       <= 1'b0;
            ovf_r        <= 1'b0;
        end else if (FrameIn && active_r) begin
            edge_count_r <= frame_cnt_next_s;
            frame_cnt_r  <= 16'd0;
            done_r       <= 1'b1;
            ovf_r        <= drop_s;
        end else begin
            frame_cnt_r  <= frame_cnt_next_s;
            done_r       <= 1'b0;
            ovf_r        <= ovf_r | drop_s;
        end
    end

    assign PointX     = mem_x_r[rd_ptr_r];
    assign PointY     = mem_y_r[rd_ptr_r];
    assign PointValid = valid_r;
    assign Overflow   = ovf_r;
    assign EdgeCount  = edge_count_r;
    assign FrameDone  = done_r;

endmodule

// File: doc/edge_point_extract.md
EDGE_POINT_EXTRACT -- requirements
Module: edge_point_extract

Interface
REQ-001 Parameter: DEPTH, 16, point FIFO entries; power of 2, 4..256.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 nReset  input  1  reset; asynchronous, active-low; clock Clk.
REQ-004 PixelIn  input  8  edge-magnitude pixel, one per cycle, from the edge-detection stage.
REQ-005 FrameIn  input  1  one-cycle strobe coincident with first pixel of a frame.
REQ-006 LineIn  input  1  one-cycle strobe coincident with first pixel of each line.
REQ-007 Width  input  8  image width in pixels; static within a frame.
REQ-008 Height  input  8  image height in lines; static within a frame.
REQ-009 Threshold  input  8  minimum magnitude for an edge point.
REQ-010 PointX  output  8  x coordinate of FIFO head.
REQ-011 PointY  output  8  y coordinate of FIFO head.
REQ-012 PointValid  output  1  FIFO head valid.
REQ-013 PointReady  input  1  consumer (Hough voter) accepts head.
REQ-014 Overflow  output  1  sticky: a point was dropped in current frame.
REQ-015 EdgeCount  output  16  accepted points of previous frame.
REQ-016 FrameDone  output  1  one-cycle pulse when EdgeCount updates.

Function
REQ-017 Coordinates: pixel with FrameIn gets (0,0); pixel with LineIn only gets x=0, y=prev y+1; else x=prev x+1, y unchanged; x and y saturate at 255.
REQ-018 FrameIn implies a line start regardless of LineIn.
REQ-019 Inactive from reset until first FrameIn; no candidates while inactive.
REQ-020 Candidate iff active, PixelIn >= Threshold, 1 <= x <= Width-2, 1 <= y <= Height-2 (border masked for 3x3 kernel); Width or Height < 3 -> no candidates.
REQ-021 Candidate (x,y) registered one stage, then pushed; latency PixelIn to PointValid = 2 cycles with FIFO empty.
REQ-022 FIFO first-word-fall-through; PointX/PointY/PointValid registered or driven from storage, no combinational path from PixelIn.
REQ-023 Pop when PointValid && PointReady; head stable while PointValid && !PointReady.
REQ-024 Push when full and no pop same cycle: point dropped, Overflow set; push when full with simultaneous pop: accepted.
REQ-025 Empty: PointValid=0, PointX/PointY don't-care, PointReady ignored.
REQ-026 Pointers wrap modulo DEPTH; occupancy counter 0..DEPTH distinguishes full/empty.
REQ-027 Per-frame counter increments on each accepted push, saturates at 65535.
REQ-028 On FrameIn (while active): EdgeCount <= counter value including any push accepted that cycle, counter cleared, FrameDone=1 next cycle, Overflow cleared unless a drop occurs that same cycle.
REQ-029 First FrameIn after reset: no FrameDone, EdgeCount stays 0.
REQ-030 FIFO not flushed at FrameIn; previous-frame points drain in order ahead of new ones.
REQ-031 FrameIn and LineIn in same cycle as pending pipeline candidate: pipeline candidate belongs to old frame and is counted to old frame.

Reset
REQ-032 nReset low: FIFO emptied, PointValid=0, PointX=PointY=0, Overflow=0, EdgeCount=0, FrameDone=0, counters and active flag cleared, pipeline candidate cleared.
REQ-033 Reset mid-frame: all in-flight points discarded; resumes only at next FrameIn.

Verification
REQ-034 Width=Height=5, Threshold=10, all pixels 20, PointReady=1 -> 9 points (1,1)..(3,3) in raster order, first PointValid 2 cycles after pixel (1,1); next FrameIn -> FrameDone pulse, EdgeCount=9.
REQ-035 Same frame, Threshold=21 -> no PointValid; EdgeCount=0 at next FrameIn; Threshold=0 -> 9 points.
REQ-036 DEPTH=16, PointReady=0, Width=Height=10, all pixels 255 -> 16 held, Overflow=1 after 17th candidate, head stays (1,1); EdgeCount=16 at next FrameIn, Overflow cleared.
REQ-037 FIFO full, PointReady=1 for one cycle coincident with candidate push -> occupancy stays 16, no Overflow.
REQ-038 Pixels before any FrameIn with LineIn toggling -> no points; assert nReset mid-frame with 5 queued -> PointValid=0 immediately, nothing until next FrameIn.
